// File: rtl/data_sram_if.sv
// Data-SRAM request/response bus between the EXE/MEM pipeline (master) and the
// memory-side responder (slave).
`timescale 1ns/1ps
interface data_sram_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_is_wr;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_is_wr
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_is_wr
  );
endinterface

// File: rtl/data_sram_responder.sv
// Memory-side responder for the data-SRAM bus: fixed-latency, in-order responses
// through a credit-limited FIFO. Define DSRAM_BACKPRESSURE_EN for LFSR-driven stalls.
`timescale 1ns/1ps
module data_sram_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  data_sram_if.slave                   bus,
  output logic [$clog2(RSP_DEPTH):0]   outstanding
);

  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(RSP_DEPTH - 1);

  logic [31:0]       mem [1 << ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              is_wr;
  logic              accept;
  logic              credit_ok;
  logic [31:0]       in_d;

  logic              push_v;
  logic              push_wr;
  logic [31:0]       push_d;

  logic [31:0]       fifo_d [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fifo_wr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic              pop;
  logic              not_empty;

  logic              unused_addr;

  assign idx         = bus.req_addr[ADDR_W+1:2];
  assign unused_addr = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};
  assign is_wr       = |bus.req_we;
  assign credit_ok   = outstanding < DEPTH_C;

`ifdef DSRAM_BACKPRESSURE_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= 8'hA5;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign bus.req_ready = credit_ok && resetn && !lfsr[0];
`else
  assign bus.req_ready = credit_ok && resetn;
`endif

  assign accept = bus.req_valid && bus.req_ready;

  // Array is deliberately not reset so contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (accept && is_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.req_we[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  // Reads sample the array at the accept edge; a write accepted one edge
  // earlier has already landed, so there is no stale window.
  assign in_d = is_wr ? '0 : mem[idx];

  generate
    if (LATENCY == 1) begin : g_nopipe
      assign push_v  = accept;
      assign push_wr = is_wr;
      assign push_d  = in_d;
    end else begin : g_pipe
      localparam int unsigned NS = LATENCY - 1;
      logic [NS-1:0] pv;
      logic [NS-1:0] pw;
      logic [31:0]   pd [NS];

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          pv <= '0;
          pw <= '0;
          for (int unsigned i = 0; i < NS; i++) pd[i] <= '0;
        end else begin
          pv[0] <= accept;
          pw[0] <= is_wr;
          pd[0] <= in_d;
          for (int unsigned i = 1; i < NS; i++) begin
            pv[i] <= pv[i-1];
            pw[i] <= pw[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign push_v  = pv[NS-1];
      assign push_wr = pw[NS-1];
      assign push_d  = pd[NS-1];
    end
  endgenerate

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign not_empty = fifo_cnt != '0;
  assign pop       = not_empty && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (push_v) begin
      fifo_d[wr_ptr]  <= push_d;
      fifo_wr[wr_ptr] <= push_wr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_v) wr_ptr <= ptr_next(wr_ptr);
      if (pop)    rd_ptr <= ptr_next(rd_ptr);
      case ({push_v, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credits cover pipe plus FIFO, so the FIFO can never be pushed while full.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_comb begin
    bus.rsp_valid = not_empty;
    bus.rsp_rdata = '0;
    bus.rsp_is_wr = 1'b0;
    if (not_empty) begin
      bus.rsp_rdata = fifo_d[rd_ptr];
      bus.rsp_is_wr = fifo_wr[rd_ptr];
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with a reference word model and an
// in-order response scoreboard.
`timescale 1ns/1ps
module tb_data_sram_responder;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned LATENCY   = 2;
  localparam int unsigned RSP_DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       resetn = 1'b0;
  logic [$clog2(RSP_DEPTH):0] outstanding;

  data_sram_if bus ();

  data_sram_responder #(
    .ADDR_W    (ADDR_W),
    .LATENCY   (LATENCY),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .outstanding (outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [31:0] rdata;
    int unsigned exp_cyc;
    bit          strict_lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pop_log[$];
  logic [31:0] model [1 << ADDR_W];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned acc_cnt = 0;
  bit          strict_lat = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] logat(input int i);
    return (pop_log.size() > i) ? pop_log[i] : 32'hxxxx_xxxx;
  endfunction

  // Monitor: compare responses at pop time, record expected results at accept time.
  always @(negedge clk) begin
    exp_t e;
    logic [ADDR_W-1:0] widx;
    if (resetn) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_is_wr", 32'(bus.rsp_is_wr), 32'(e.is_wr));
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_latency",
              32'(e.strict_lat ? (cyc == e.exp_cyc) : (cyc >= e.exp_cyc)), 32'd1);
          pop_log.push_back(bus.rsp_rdata);
        end
      end else if (!bus.rsp_valid) begin
        chk("idle_rdata", bus.rsp_rdata, 32'd0);
        chk("idle_is_wr", 32'(bus.rsp_is_wr), 32'd0);
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cnt++;
        widx = bus.req_addr[ADDR_W+1:2];
        if (bus.req_we != 4'b0000) begin
          for (int i = 0; i < 4; i++)
            if (bus.req_we[i]) model[widx][8*i +: 8] = bus.req_wdata[8*i +: 8];
          e = '{1'b1, 32'd0, cyc + LATENCY, strict_lat};
        end else begin
          e = '{1'b0, model[widx], cyc + LATENCY, strict_lat};
        end
        sb.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 4'b0000;
  endtask

  task automatic drain();
    int n = 0;
    while ((outstanding != 0 || sb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned a0;
    bus.req_valid = 1'b0;
    bus.req_we    = 4'b0000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    resetn        = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rel_outstanding", 32'(outstanding), 32'd0);
    @(posedge clk);
    #1;

    // Full write then read of the same word on the next cycle.
    bus.rsp_ready = 1'b1;
    strict_lat    = 1'b1;
    pop_log.delete();
    issue(4'hF, 32'h1c00_0010, 32'h1234_5678);
    issue(4'h0, 32'h1c00_0010, 32'h0);
    drain();
    chk("wr_ack_rdata", logat(0), 32'd0);
    chk("rd_after_wr", logat(1), 32'h1234_5678);

    // Partial lane write.
    pop_log.delete();
    issue(4'b0010, 32'h1c00_0010, 32'h0000_AB00);
    issue(4'h0, 32'h1c00_0010, 32'h0);
    drain();
    chk("partial_write", logat(1), 32'h1234_AB78);

    // Back-to-back writes and reads with rsp_ready held high.
    for (int i = 0; i < 6; i++)
      issue(4'hF, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i * 17));
    for (int i = 0; i < 4; i++)
      issue(4'h0, 32'h100 + 32'(4 * i), 32'h0);
    drain();

    // Fill all credits with the consumer stalled.
    strict_lat    = 1'b0;
    bus.rsp_ready = 1'b0;
    pop_log.delete();
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++)
      issue(4'h0, 32'h100 + 32'(4 * i), 32'h0);
    bus.req_valid = 1'b1;
    bus.req_we    = 4'h0;
    bus.req_addr  = 32'h110;
    repeat (2) @(negedge clk);
    bus.req_addr  = 32'h114;
    @(negedge clk);
    chk("full_accepts", acc_cnt - a0, 32'd4);
    chk("full_req_ready", 32'(bus.req_ready), 32'd0);
    chk("full_outstanding", 32'(outstanding), 32'd4);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("pop_cycle_ready", 32'(bus.req_ready), 32'd0);
    chk("pop_cycle_valid", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    chk("after_pop_ready", 32'(bus.req_ready), 32'd1);
    chk("after_pop_outstanding", 32'(outstanding), 32'd3);
    drain();
    for (int i = 0; i < 4; i++)
      chk("order", logat(i), 32'hA000_0000 + 32'(i * 17));

    // Address aliasing modulo the array size.
    strict_lat = 1'b1;
    pop_log.delete();
    issue(4'hF, 32'h0000_0000, 32'hCAFE_F00D);
    issue(4'h0, 32'h0000_0000, 32'h0);
    issue(4'h0, 32'h0000_1000, 32'h0);
    drain();
    chk("alias_base", logat(1), 32'hCAFE_F00D);
    chk("alias_high", logat(2), 32'hCAFE_F00D);

    // Reset with three responses in flight.
    strict_lat    = 1'b0;
    bus.rsp_ready = 1'b0;
    issue(4'h0, 32'h100, 32'h0);
    issue(4'h0, 32'h104, 32'h0);
    issue(4'h0, 32'h108, 32'h0);
    @(negedge clk);
    chk("pre_rst_outstanding", 32'(outstanding), 32'd3);
    chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    #2;
    resetn = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_rst_outstanding", 32'(outstanding), 32'd0);
    chk("async_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("async_rst_rdata", bus.rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rerel_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rerel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    strict_lat    = 1'b1;
    bus.rsp_ready = 1'b1;
    pop_log.delete();
    issue(4'h0, 32'h1c00_0010, 32'h0);
    drain();
    chk("mem_kept_over_reset", logat(0), 32'h1234_AB78);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
